// File: rtl/q2a03_pkg.sv
// Q2A03 bus-sequencer shared definitions: default timing, skip encodings,
// request record and the T-state shift helper.
package q2a03_pkg;

  localparam int DIV_DEFAULT        = 12;
  localparam int PHI2_START_DEFAULT = 6;
  localparam int ADDR_W_DEFAULT     = 16;
  localparam int DATA_W_DEFAULT     = 8;

  // Number of extra T-states skipped at the next sequencer advance.
  localparam logic [1:0] SKIP_NONE = 2'd0;
  localparam logic [1:0] SKIP_1    = 2'd1;
  localparam logic [1:0] SKIP_2    = 2'd2;
  localparam logic [1:0] SKIP_3    = 2'd3;

  // One datapath transaction as presented by the core.
  typedef struct packed {
    logic                      write;
    logic [ADDR_W_DEFAULT-1:0] addr;
    logic [DATA_W_DEFAULT-1:0] wdata;
  } q2a03_req_t;

  // Shift distance applied to the one-hot T-state on a normal advance.
  function automatic logic [4:0] skip_shift(input logic [1:0] skip);
    return {3'b000, skip} + 5'd1;
  endfunction

endpackage

// File: rtl/q2a03_clk_div.sv
// Master-clock divider: tick counter 0..DIV-1, registered phi2 phase and the
// end-of-cycle strobe. Shared with the PPU/APU timing blocks.
module q2a03_clk_div
  import q2a03_pkg::*;
#(
  parameter int DIV        = DIV_DEFAULT,
  parameter int PHI2_START = PHI2_START_DEFAULT,
  parameter int TICK_W     = $clog2(DIV)
) (
  input  logic              G_clock,
  input  logic              G_reset,
  output logic [TICK_W-1:0] tick,
  output logic              G_phy2,
  output logic              cyc_end
);

  logic [TICK_W-1:0] tick_r;
  logic [TICK_W-1:0] tick_s;
  logic              phy2_r;
  logic              phy2_s;
  logic              cyc_end_s;

  // Next tick value and the phi2 level that goes with it.
  always_comb begin
    cyc_end_s = (tick_r == TICK_W'(DIV - 1));
    tick_s    = tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
    if (cyc_end_s) begin
      tick_s = {TICK_W{1'b0}};
    end else begin
      tick_s = tick_r + {{(TICK_W-1){1'b0}}, 1'b1};
    end
    phy2_s = (tick_s >= TICK_W'(PHI2_START));
  end

  // Tick counter and phi2 phase register.
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      tick_r <= {TICK_W{1'b0}};
      phy2_r <= 1'b0;
    end else begin
      tick_r <= tick_s;
      phy2_r <= phy2_s;
    end
  end

  assign tick    = tick_r;
  assign G_phy2  = phy2_r;
  assign cyc_end = cyc_end_s;

endmodule

// File: rtl/q2a03_bus_sequencer.sv
// Q2A03 bus-cycle engine: one bus transaction per CPU cycle, read stalls on
// G_ready, one-hot T-state sequencer with skip/restart.
// Optional build macro Q2A03_BUS_STALL_CNT_EN adds stall_clr / stall_cnt.
module q2a03_bus_sequencer
  import q2a03_pkg::*;
#(
  parameter int DIV        = DIV_DEFAULT,
  parameter int PHI2_START = PHI2_START_DEFAULT,
  parameter int CYCLE_W    = 8,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8
) (
  input  logic               G_clock,
  input  logic               G_reset,
  input  logic               G_ready,
  input  logic [DATA_W-1:0]  G_rd_data,
  output logic [ADDR_W-1:0]  G_addr,
  output logic [DATA_W-1:0]  G_wr_data,
  output logic               G_rdwr,
  output logic               G_phy2,
  output logic               G_sync,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  output logic               rsp_valid,
  output logic [DATA_W-1:0]  rsp_data,
  input  logic [1:0]         seq_skip,
  input  logic               seq_restart,
  output logic [CYCLE_W-1:0] cycle,
  output logic               cyc_end
`ifdef Q2A03_BUS_STALL_CNT_EN
  ,
  input  logic               stall_clr,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int TICK_W = $clog2(DIV);

  logic [TICK_W-1:0]  tick_s;
  logic               cyc_end_s;
  logic               req_ready_s;
  logic               stall_event_s;

  logic [ADDR_W-1:0]  addr_r,      addr_s;
  logic [DATA_W-1:0]  wdata_r,     wdata_s;
  logic               rdwr_r,      rdwr_s;
  logic               stall_r,     stall_s;
  logic               rsp_valid_r, rsp_valid_s;
  logic [DATA_W-1:0]  rsp_data_r,  rsp_data_s;
  logic [CYCLE_W-1:0] cycle_r,     cycle_s;

  // Restart wins over skip; bits pushed past the top are lost, so an
  // all-zero state sticks until the next restart.
  function automatic logic [CYCLE_W-1:0] advance_cycle(
    input logic [CYCLE_W-1:0] cur,
    input logic [1:0]         skip,
    input logic               restart
  );
    logic [CYCLE_W-1:0] nxt;
    if (restart) begin
      nxt = {{(CYCLE_W-1){1'b0}}, 1'b1};
    end else begin
      nxt = cur << skip_shift(skip);
    end
    return nxt;
  endfunction

  q2a03_clk_div #(
    .DIV        (DIV),
    .PHI2_START (PHI2_START),
    .TICK_W     (TICK_W)
  ) u_clk_div (
    .G_clock (G_clock),
    .G_reset (G_reset),
    .tick    (tick_s),
    .G_phy2  (G_phy2),
    .cyc_end (cyc_end_s)
  );

  assign req_ready_s   = (tick_s == {TICK_W{1'b0}}) && !stall_r;
  assign stall_event_s = cyc_end_s && rdwr_r && !G_ready;

  // Request latch at tick 0, then end-of-cycle completion or read stall.
  always_comb begin
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rdwr_s      = rdwr_r;
    stall_s     = stall_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;
    cycle_s     = cycle_r;
    if (req_ready_s) begin
      if (req_valid) begin
        addr_s  = req_addr;
        wdata_s = req_wdata;
        rdwr_s  = !req_write;
      end else begin
        rdwr_s  = 1'b1;
      end
    end else if (cyc_end_s) begin
      if (stall_event_s) begin
        stall_s = 1'b1;
      end else begin
        stall_s     = 1'b0;
        rsp_valid_s = 1'b1;
        if (rdwr_r) begin
          rsp_data_s = G_rd_data;
        end else begin
          rsp_data_s = rsp_data_r;
        end
        cycle_s = advance_cycle(cycle_r, seq_skip, seq_restart);
      end
    end else begin
      rsp_valid_s = 1'b0;
    end
  end

  // Bus, response and sequencer state registers.
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      rdwr_r      <= 1'b1;
      stall_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      cycle_r     <= {{(CYCLE_W-1){1'b0}}, 1'b1};
    end else begin
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rdwr_r      <= rdwr_s;
      stall_r     <= stall_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      cycle_r     <= cycle_s;
    end
  end

`ifdef Q2A03_BUS_STALL_CNT_EN
  logic [15:0] stall_cnt_r, stall_cnt_s;

  // Saturating count of stalled CPU cycles; clear has priority.
  always_comb begin
    stall_cnt_s = stall_cnt_r;
    if (stall_clr) begin
      stall_cnt_s = 16'h0000;
    end else if (stall_event_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_s = stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // Stall counter register.
  always_ff @(posedge G_clock or negedge G_reset) begin
    if (!G_reset) begin
      stall_cnt_r <= 16'h0000;
    end else begin
      stall_cnt_r <= stall_cnt_s;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  // Stall counting not built: no counter state.
`endif

  assign G_addr    = addr_r;
  assign G_wr_data = wdata_r;
  assign G_rdwr    = rdwr_r;
  assign G_sync    = cycle_r[0];
  assign req_ready = req_ready_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign cycle     = cycle_r;
  assign cyc_end   = cyc_end_s;

endmodule

// File: tb/tb_q2a03_bus_sequencer.sv
// Self-checking bench for q2a03_bus_sequencer: directed scenarios followed by
// random CPU cycles compared against a cycle-level reference model.
module tb_q2a03_bus_sequencer;
  import q2a03_pkg::*;

  localparam int DIV        = 12;
  localparam int PHI2_START = 6;
  localparam int CYCLE_W    = 8;
  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 8;

  logic               G_clock = 1'b0;
  logic               G_reset;
  logic               G_ready;
  logic [DATA_W-1:0]  G_rd_data;
  logic [ADDR_W-1:0]  G_addr;
  logic [DATA_W-1:0]  G_wr_data;
  logic               G_rdwr;
  logic               G_phy2;
  logic               G_sync;
  logic               req_valid;
  logic               req_ready;
  logic               req_write;
  logic [ADDR_W-1:0]  req_addr;
  logic [DATA_W-1:0]  req_wdata;
  logic               rsp_valid;
  logic [DATA_W-1:0]  rsp_data;
  logic [1:0]         seq_skip;
  logic               seq_restart;
  logic [CYCLE_W-1:0] cycle;
  logic               cyc_end;
`ifdef Q2A03_BUS_STALL_CNT_EN
  logic               stall_clr;
  logic [15:0]        stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: bus state per CPU cycle; T-state kept as a position
  // index (CYCLE_W means "shifted out").
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic              m_rdwr;
  logic [DATA_W-1:0] m_rsp;
  int                m_pos;
  bit                m_stall;
  bit                m_pending;
  int                m_stall_cnt;

  q2a03_bus_sequencer #(
    .DIV(DIV), .PHI2_START(PHI2_START), .CYCLE_W(CYCLE_W),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .G_clock(G_clock), .G_reset(G_reset), .G_ready(G_ready),
    .G_rd_data(G_rd_data), .G_addr(G_addr), .G_wr_data(G_wr_data),
    .G_rdwr(G_rdwr), .G_phy2(G_phy2), .G_sync(G_sync),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .seq_skip(seq_skip), .seq_restart(seq_restart),
    .cycle(cycle), .cyc_end(cyc_end)
`ifdef Q2A03_BUS_STALL_CNT_EN
    , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
  );

  always #5 G_clock = ~G_clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CYCLE_W-1:0] exp_cycle(input int pos);
    logic [CYCLE_W-1:0] v;
    v = '0;
    if (pos < CYCLE_W) v[pos] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_addr      = '0;
    m_wdata     = '0;
    m_rdwr      = 1'b1;
    m_rsp       = '0;
    m_pos       = 0;
    m_stall     = 0;
    m_pending   = 0;
    m_stall_cnt = 0;
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_addr"},      G_addr, '0);
    check_val({pfx, "_wdata"},     G_wr_data, '0);
    check_val({pfx, "_rdwr"},      G_rdwr, 1);
    check_val({pfx, "_phy2"},      G_phy2, 0);
    check_val({pfx, "_cycle"},     cycle, 1);
    check_val({pfx, "_sync"},      G_sync, 1);
    check_val({pfx, "_rsp_valid"}, rsp_valid, 0);
    check_val({pfx, "_rsp_data"},  rsp_data, '0);
    check_val({pfx, "_cyc_end"},   cyc_end, 0);
    check_val({pfx, "_req_ready"}, req_ready, 1);
`ifdef Q2A03_BUS_STALL_CNT_EN
    check_val({pfx, "_stall_cnt"}, stall_cnt, 0);
`endif
  endtask

  // One CPU cycle; entered and left at the falling edge where tick is 0.
  // reset_at (1..DIV-1) pulses G_reset at that tick, 0 means no reset.
  task automatic cpu_cycle(input logic rv, input logic wr, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd, input logic rdy,
                           input logic [DATA_W-1:0] rdd, input logic [1:0] sk,
                           input logic rs, input int reset_at);
    check_val("t0_rsp_valid", rsp_valid, m_pending);
    check_val("t0_rsp_data",  rsp_data, m_rsp);
    check_val("t0_cycle",     cycle, exp_cycle(m_pos));
    check_val("t0_sync",      G_sync, (m_pos == 0));
    check_val("t0_req_ready", req_ready, !m_stall);
    check_val("t0_phy2",      G_phy2, 0);
    check_val("t0_cyc_end",   cyc_end, 0);
`ifdef Q2A03_BUS_STALL_CNT_EN
    check_val("t0_stall_cnt", stall_cnt, m_stall_cnt);
`endif
    m_pending = 0;
    req_valid = rv && !m_stall;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    if (!m_stall) begin
      if (req_valid) begin
        m_addr  = a;
        m_wdata = wd;
        m_rdwr  = !wr;
      end else begin
        m_rdwr  = 1'b1;
      end
    end
    for (int k = 1; k < DIV; k++) begin
      @(negedge G_clock);
      req_valid = 1'b0;
      if (k == reset_at) begin
        G_reset = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(negedge G_clock);
        G_reset = 1'b1;
        model_reset();
        return;
      end
      check_val("phy2",      G_phy2, (k >= PHI2_START));
      check_val("cyc_end",   cyc_end, (k == DIV - 1));
      check_val("req_ready", req_ready, 0);
      check_val("rsp_valid", rsp_valid, 0);
      check_val("addr",      G_addr, m_addr);
      check_val("wdata",     G_wr_data, m_wdata);
      check_val("rdwr",      G_rdwr, m_rdwr);
    end
    G_ready     = rdy;
    G_rd_data   = rdd;
    seq_skip    = sk;
    seq_restart = rs;
    if (m_rdwr && !rdy) begin
      m_stall = 1;
      if (m_stall_cnt < 16'hFFFF) m_stall_cnt++;
    end else begin
      m_stall   = 0;
      m_pending = 1;
      if (m_rdwr) m_rsp = rdd;
      if (rs) begin
        m_pos = 0;
      end else if (m_pos < CYCLE_W) begin
        m_pos = m_pos + 1 + int'(sk);
        if (m_pos > CYCLE_W) m_pos = CYCLE_W;
      end
    end
    @(negedge G_clock);
    G_ready     = 1'b1;
    seq_skip    = SKIP_NONE;
    seq_restart = 1'b0;
  endtask

  initial begin
    q2a03_req_t r;
    G_reset     = 1'b0;
    G_ready     = 1'b1;
    G_rd_data   = '0;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_addr    = '0;
    req_wdata   = '0;
    seq_skip    = SKIP_NONE;
    seq_restart = 1'b0;
`ifdef Q2A03_BUS_STALL_CNT_EN
    stall_clr   = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge G_clock);
    check_reset_values("rst");
    G_reset = 1'b1;

    // Read 0x8000 returning 0xA9.
    cpu_cycle(1, 0, 16'h8000, 8'h00, 1, 8'hA9, SKIP_NONE, 0, 0);
    check_val("dir_rd_data", rsp_data, 8'hA9);
    check_val("dir_rd_cycle", cycle, 8'h02);
    // Write 0x0200 <- 0x55 with ready low: completes, no stall.
    cpu_cycle(1, 1, 16'h0200, 8'h55, 0, 8'hEE, SKIP_NONE, 0, 0);
    check_val("dir_wr_rsp", rsp_valid, 1);
    check_val("dir_wr_keep", rsp_data, 8'hA9);
    check_val("dir_wr_cycle", cycle, 8'h04);
    // Read 0x4000 stalled two CPU cycles; skip/restart ignored while stalled.
    cpu_cycle(1, 0, 16'h4000, 8'h00, 0, 8'h11, SKIP_3, 1, 0);
    check_val("dir_stall1_rsp", rsp_valid, 0);
    check_val("dir_stall1_cycle", cycle, 8'h04);
    cpu_cycle(1, 1, 16'h1234, 8'h77, 0, 8'h22, SKIP_1, 0, 0);
    check_val("dir_stall2_addr", G_addr, 16'h4000);
    cpu_cycle(0, 0, 16'h0000, 8'h00, 1, 8'h3C, SKIP_2, 0, 0);
    check_val("dir_stall_data", rsp_data, 8'h3C);
    check_val("dir_skip2_cycle", cycle, 8'h20);
`ifdef Q2A03_BUS_STALL_CNT_EN
    check_val("dir_stall_cnt", stall_cnt, 16'd2);
`endif
    // Sequencer boundaries: restart, shift off the top, stuck at zero.
    cpu_cycle(0, 0, 16'h0000, 8'h00, 1, 8'h00, SKIP_2, 1, 0);
    check_val("dir_restart", cycle, 8'h01);
    cpu_cycle(0, 0, 16'h0000, 8'h00, 1, 8'h00, SKIP_3, 0, 0);
    cpu_cycle(0, 0, 16'h0000, 8'h00, 1, 8'h00, SKIP_2, 0, 0);
    check_val("dir_cycle128", cycle, 8'h80);
    cpu_cycle(0, 0, 16'h0000, 8'h00, 1, 8'h00, SKIP_NONE, 0, 0);
    check_val("dir_cycle0", cycle, 8'h00);
    check_val("dir_sync0", G_sync, 0);
    cpu_cycle(0, 0, 16'h0000, 8'h00, 1, 8'h00, SKIP_NONE, 0, 0);
    check_val("dir_stuck0", cycle, 8'h00);
    cpu_cycle(0, 0, 16'h0000, 8'h00, 1, 8'h00, SKIP_1, 1, 0);
    check_val("dir_unstuck", cycle, 8'h01);
    // Reset in the middle of a read: no response, request taken right after.
    cpu_cycle(1, 0, 16'hC000, 8'h00, 1, 8'h99, SKIP_NONE, 0, 7);
    cpu_cycle(1, 0, 16'hC001, 8'h00, 1, 8'h42, SKIP_NONE, 0, 0);
    check_val("dir_post_rst_addr", G_addr, 16'hC001);

    // Randomised CPU cycles.
    for (int i = 0; i < 150; i++) begin
      int rst_at;
      r.write = 1'($urandom_range(0, 1));
      r.addr  = 16'($urandom);
      r.wdata = 8'($urandom);
      rst_at  = ($urandom_range(0, 39) == 0) ? int'($urandom_range(1, DIV - 1)) : 0;
      cpu_cycle(1'($urandom_range(0, 3) != 0), r.write, r.addr, r.wdata,
                1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 5) == 0), rst_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
